// File: rtl/ksa_engine.sv
// ksa_engine: RC4-style key-scheduling engine driving an external single-port
// synchronous S memory. Runs an optional identity fill (S[i]=i) and then the
// key-scheduling permutation, with a rdy/en handshake and a one-cycle done pulse.
// Each index takes four cycles: RD_I presents i, CAP_I captures S[i] and
// presents j' combinationally, WR_I writes the word read from j' straight into
// S[i] (the sj capture happens there), and WR_J writes si into S[j].
module ksa_engine #(
  parameter int W        = 8,
  parameter int KEY_SYMS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  init_en,
  input  logic [W*KEY_SYMS-1:0] key,
  output logic                  rdy,
  output logic                  done,
  output logic [W-1:0]          addr,
  input  logic [W-1:0]          rddata,
  output logic [W-1:0]          wrdata,
  output logic                  wren
);

  localparam int KW = (KEY_SYMS > 1) ? $clog2(KEY_SYMS) : 1;
  localparam logic [W-1:0]  I_LAST = '1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_SYMS - 1);

  // CAP_J is part of the state vocabulary but its capture is folded into
  // WR_I so that every index costs exactly four cycles.
  typedef enum logic [2:0] {
    IDLE, FILL, RD_I, CAP_I, CAP_J, WR_I, WR_J
  } state_t;

  state_t                  state;
  logic [W-1:0]            i_reg;
  logic [W-1:0]            j_reg;
  logic [W-1:0]            si_reg;
  logic [KW-1:0]           kidx_reg;
  logic [W*KEY_SYMS-1:0]   key_reg;
  logic                    done_reg;

  logic [W-1:0]            key_sym [KEY_SYMS];
  logic [W-1:0]            j_next;

  // Split the latched key into symbols; symbol 0 is the most significant.
  generate
    for (genvar gi = 0; gi < KEY_SYMS; gi++) begin : g_key_sym
      assign key_sym[gi] = key_reg[W*(KEY_SYMS-gi)-1 -: W];
    end
  endgenerate

  // New j from the S[i] word arriving during CAP_I.
  assign j_next = j_reg + rddata + key_sym[kidx_reg];

  assign rdy  = (state == IDLE);
  assign done = done_reg;

  // Memory port decode; addr and wrdata default to zero whenever unused.
  always_comb begin
    addr   = '0;
    wrdata = '0;
    wren   = 1'b0;
    case (state)
      FILL: begin
        addr   = i_reg;
        wrdata = i_reg;
        wren   = 1'b1;
      end
      RD_I:  addr = i_reg;
      CAP_I: addr = j_next;
      WR_I: begin
        addr   = i_reg;
        wrdata = rddata;
        wren   = 1'b1;
      end
      WR_J: begin
        addr   = j_reg;
        wrdata = si_reg;
        wren   = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer: fill, then read-i / read-j / write-i / write-j per index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i_reg    <= '0;
      j_reg    <= '0;
      si_reg   <= '0;
      kidx_reg <= '0;
      key_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            key_reg  <= key;
            i_reg    <= '0;
            j_reg    <= '0;
            kidx_reg <= '0;
            state    <= init_en ? FILL : RD_I;
          end
        end
        FILL: begin
          if (i_reg == I_LAST) begin
            i_reg <= '0;
            j_reg <= '0;
            state <= RD_I;
          end else begin
            i_reg <= i_reg + 1'b1;
          end
        end
        RD_I: state <= CAP_I;
        CAP_I: begin
          si_reg <= rddata;
          j_reg  <= j_next;
          state  <= WR_I;
        end
        WR_I: state <= WR_J;
        WR_J: begin
          if (i_reg == I_LAST) begin
            i_reg    <= '0;
            kidx_reg <= '0;
            done_reg <= 1'b1;
            state    <= IDLE;
          end else begin
            i_reg    <= i_reg + 1'b1;
            kidx_reg <= (kidx_reg == K_LAST) ? '0 : kidx_reg + 1'b1;
            state    <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
